// File: rtl/hazard_pkg.sv
// hazard_pkg: writeback source codes, tag widths and the tag record shared by the hazard scoreboard
package hazard_pkg;
    localparam int REG_AW = 5;
    localparam int WS_W   = 3;
    typedef enum logic [WS_W-1:0] {
        WS_ALU   = 3'd0,
        WS_MEM   = 3'd1,
        WS_PC8   = 3'd2,
        WS_HI    = 3'd3,
        WS_LO    = 3'd4,
        WS_SHIFT = 3'd5
    } ws_src_e;
    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] wa;
        logic [WS_W-1:0]   ws;
    } tag_t;
    localparam tag_t TAG_BUBBLE = '0;
endpackage

// File: rtl/hazard_scoreboard_md_busy_ctr.sv
// md_busy_ctr: mul/div occupancy counter, loads LAT on issue and counts down to idle
module md_busy_ctr #(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic busy_o
);
    localparam int CW = $clog2(LAT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // reload on issue, otherwise drain toward zero
    always_comb cnt_d = load_i ? CW'(LAT) : ((cnt_q != '0) ? cnt_q - CW'(1) : cnt_q);
    // count register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: E/M/W destination-tag pipeline with RAW-on-E stall; mul/div interlock under HAZARD_MD_INTERLOCK_EN
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_we,
    input  logic [REG_AW-1:0] id_wa,
    input  logic [WS_W-1:0]   id_ws,
    input  logic [REG_AW-1:0] id_ra1,
    input  logic [REG_AW-1:0] id_ra2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic              id_md_start,
    input  logic              id_reads_hilo,
    output logic              WE_EM,
    output logic [REG_AW-1:0] WA_EM,
    output logic [WS_W-1:0]   WS_EM,
    output logic              we_mw,
    output logic [REG_AW-1:0] wa_mw,
    output logic [WS_W-1:0]   ws_mw,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic              md_busy
);
    tag_t e_q, e_d, m_q, w_q;
    logic raw_e, md_hz, stall, advance;
    assign raw_e = id_valid & e_q.we & (e_q.wa != '0) &
                   ((id_use1 & (id_ra1 == e_q.wa)) | (id_use2 & (id_ra2 == e_q.wa)));
    assign stall   = raw_e | md_hz;
    assign advance = id_valid & ~stall;
    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;
`ifdef HAZARD_MD_INTERLOCK_EN
    md_busy_ctr #(.LAT(MD_LATENCY)) u_md (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (advance & id_md_start),
        .busy_o (md_busy)
    );
    assign md_hz = id_valid & md_busy & (id_reads_hilo | id_md_start);
`else
    logic unused_md;
    assign unused_md = ^{id_md_start, id_reads_hilo, (MD_LATENCY != 0)};
    assign md_busy   = 1'b0;
    assign md_hz     = 1'b0;
`endif
    // E takes the D tag only when a real instruction advances; stalls and empty slots become bubbles
    always_comb e_d = advance ? tag_t'{we: id_we, wa: id_wa, ws: id_ws} : TAG_BUBBLE;
    // tag pipeline: E from D, then M and W shift unconditionally
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            e_q <= TAG_BUBBLE;
            m_q <= TAG_BUBBLE;
            w_q <= TAG_BUBBLE;
        end else begin
            e_q <= e_d;
            m_q <= e_q;
            w_q <= m_q;
        end
    assign WE_EM = m_q.we;
    assign WA_EM = m_q.wa;
    assign WS_EM = m_q.ws;
    assign we_mw = w_q.we;
    assign wa_mw = w_q.wa;
    assign ws_mw = w_q.ws;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven tag/stall vectors plus mul/div and reset sequences
module tb_hazard_scoreboard;
    import hazard_pkg::*;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_we, id_use1, id_use2, id_md_start, id_reads_hilo;
    logic [4:0] id_wa, id_ra1, id_ra2;
    logic [2:0] id_ws;
    logic       WE_EM, we_mw, stall_f, stall_d, flush_e, md_busy;
    logic [4:0] WA_EM, wa_mw;
    logic [2:0] WS_EM, ws_mw;
    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.MD_LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_we(id_we), .id_wa(id_wa),
        .id_ws(id_ws), .id_ra1(id_ra1), .id_ra2(id_ra2), .id_use1(id_use1),
        .id_use2(id_use2), .id_md_start(id_md_start), .id_reads_hilo(id_reads_hilo),
        .WE_EM(WE_EM), .WA_EM(WA_EM), .WS_EM(WS_EM), .we_mw(we_mw), .wa_mw(wa_mw),
        .ws_mw(ws_mw), .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v, we, u1, u2, s, mwe, wwe;
        logic [4:0] wa, ra1, ra2, mwa, wwa;
        logic [2:0] ws, mws, wws;
    } vec_t;

    function automatic vec_t mk(int v, int we, int wa, int ws, int ra1, int ra2, int u1, int u2,
                                int s, int mwe, int mwa, int mws, int wwe, int wwa, int wws);
        vec_t r;
        r.v = 1'(v); r.we = 1'(we); r.wa = 5'(wa); r.ws = 3'(ws);
        r.ra1 = 5'(ra1); r.ra2 = 5'(ra2); r.u1 = 1'(u1); r.u2 = 1'(u2);
        r.s = 1'(s); r.mwe = 1'(mwe); r.mwa = 5'(mwa); r.mws = 3'(mws);
        r.wwe = 1'(wwe); r.wwa = 5'(wwa); r.wws = 3'(wws);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [21:0] act, input logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] wa, input logic [2:0] ws,
                         input logic [4:0] ra1, input logic [4:0] ra2, input logic u1, input logic u2,
                         input logic mds, input logic hilo);
        id_valid = v; id_we = we; id_wa = wa; id_ws = ws; id_ra1 = ra1; id_ra2 = ra2;
        id_use1 = u1; id_use2 = u2; id_md_start = mds; id_reads_hilo = hilo;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [21:0] outs();
        return {stall_f, stall_d, flush_e, WE_EM, WA_EM, WS_EM, we_mw, wa_mw, ws_mw, md_busy};
    endfunction

    // D holds its instruction while stalled; expects stall/busy for 4 cycles when the interlock is built
    task automatic md_hold(input string nm);
        for (int k = 0; k < 4; k++) begin
            #1;
`ifdef HAZARD_MD_INTERLOCK_EN
            chk(nm, 22'({stall_f, md_busy}), 22'b11);
`else
            chk(nm, 22'({stall_f, md_busy}), 22'b00);
`endif
            @(negedge clk);
        end
        #1 chk({nm, "_release"}, 22'({stall_f, md_busy}), 22'b00);
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = mk(1,1,8,int'(WS_MEM),0,0,0,0, 0, 0,0,0, 0,0,0);
        vecs[1]  = mk(1,1,9,int'(WS_ALU),8,0,1,0, 1, 0,0,0, 0,0,0);
        vecs[2]  = mk(1,1,9,int'(WS_ALU),8,0,1,0, 0, 1,8,1, 0,0,0);
        vecs[3]  = mk(1,1,0,0,0,0,0,0,            0, 0,0,0, 1,8,1);
        vecs[4]  = mk(1,0,0,0,0,0,1,1,            0, 1,9,0, 0,0,0);
        vecs[5]  = mk(1,1,5,0,0,0,0,0,            0, 1,0,0, 1,9,0);
        vecs[6]  = mk(1,0,0,0,0,5,0,0,            0, 0,0,0, 1,0,0);
        vecs[7]  = mk(1,1,5,int'(WS_SHIFT),0,0,0,0, 0, 1,5,0, 0,0,0);
        vecs[8]  = mk(1,0,0,0,0,5,0,1,            1, 0,0,0, 1,5,0);
        vecs[9]  = mk(1,0,0,0,0,5,0,1,            0, 1,5,5, 0,0,0);
        vecs[10] = mk(0,1,7,0,0,0,0,0,            0, 0,0,0, 1,5,5);
        vecs[11] = mk(1,0,0,0,7,0,1,0,            0, 0,0,0, 0,0,0);
        vecs[12] = mk(1,1,7,0,0,0,0,0,            0, 0,0,0, 0,0,0);
        vecs[13] = mk(0,0,0,0,7,0,1,0,            0, 0,0,0, 0,0,0);

        do_reset();
        #1 chk("reset_state", outs(), 22'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].we, vecs[i].wa, vecs[i].ws, vecs[i].ra1, vecs[i].ra2,
                  vecs[i].u1, vecs[i].u2, 1'b0, 1'b0);
            #1 chk($sformatf("vec%0d", i), outs(),
                   {vecs[i].s, vecs[i].s, vecs[i].s, vecs[i].mwe, vecs[i].mwa, vecs[i].mws,
                    vecs[i].wwe, vecs[i].wwa, vecs[i].wws, 1'b0});
        end

        do_reset();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1 chk("md_issue", 22'({stall_f, md_busy}), 22'b00);
        @(negedge clk);
        drive(1, 1, 2, int'(WS_HI), 0, 0, 0, 0, 0, 1);
        md_hold("hilo");
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1 chk("md_issue2", 22'({stall_f, md_busy}), 22'b00);
        @(negedge clk);
        md_hold("b2b_start");

        do_reset();
        @(negedge clk);
        drive(1, 1, 8, int'(WS_LO), 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef HAZARD_MD_INTERLOCK_EN
        #1 chk("pre_rst", 22'({WE_EM, WA_EM, md_busy, stall_f}), 22'({1'b1, 5'd8, 1'b1, 1'b1}));
`else
        #1 chk("pre_rst", 22'({WE_EM, WA_EM, md_busy, stall_f}), 22'({1'b1, 5'd8, 1'b0, 1'b0}));
`endif
        #1 rst_n = 1'b0;
        #1 chk("rst_async", outs(), 22'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_release", outs(), 22'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Producer side of the decode-stage forwarding path: tracks destination tags (write address, write enable, writeback source) of in-flight instructions through the E, M and W stages and publishes the EX/MEM tags consumed by the ID forwarding unit. It detects hazards that forwarding cannot cover and issues stall and flush controls:
- a consumer in D reading a register written by the instruction currently in E;
- HI/LO reads or new mul/div starts while a multicycle mul/div is busy.

It sits beside the D/E/M/W pipeline registers in the datapath top.

## Interface
- `MD_LATENCY`, default 4: mul/div busy cycles after issue; legal range ≥ 1.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `id_valid`  in  1  D-stage slot holds a real instruction.
- `id_we`  in  1  D-stage instruction writes the register file.
- `id_wa`  in  5  D-stage destination register.
- `id_ws`  in  3  D-stage writeback source code (hazard_pkg).
- `id_ra1`, `id_ra2`  in  5 each  D-stage source registers.
- `id_use1`, `id_use2`  in  1 each  the source is actually read.
- `id_md_start`  in  1  D-stage instruction starts a mul/div.
- `id_reads_hilo`  in  1  D-stage instruction reads HI or LO.
- `WE_EM`, `WA_EM`, `WS_EM`  out  1/5/3  tags of the instruction in M.
- `we_mw`, `wa_mw`, `ws_mw`  out  1/5/3  tags of the instruction in W.
- `stall_f`, `stall_d`  out  1 each  hold PC and the F/D register.
- `flush_e`  out  1  insert a bubble into the D/E register.
- `md_busy`  out  1  mul/div unit occupied.

## Operation
- The tag pipeline holds E, M and W registers of `{we, wa, ws}`. A tag with `wa == 0` is stored as-is, but it never creates a hazard.
- Hazard terms:
  - `raw_e` = `id_valid & we_e & wa_e != 0 & ((id_use1 & id_ra1 == wa_e) | (id_use2 & id_ra2 == wa_e))`.
  - `md_hz` = `id_valid & md_busy & (id_reads_hilo | id_md_start)`.
- Stall outputs: `stall_f = stall_d = flush_e = raw_e | md_hz`.
- Each edge, unless reset is asserted:
  - E ← D tags if not stalled. If stalled, E ← bubble (`we = 0`, `wa = 0`, `ws = 0`).
  - M ← E and W ← M unconditionally.
- If `id_valid` = 0, D is loaded into E as a bubble.
- Matches in M are not hazards; the ID forwarding unit covers them using `WS_EM`. Memory data is valid in M.
- Matches in W are not hazards; the register file is write-first.
- Mul/div counter `md_cnt`, width `$clog2(MD_LATENCY+1)`:
  - loads `MD_LATENCY` when an `id_md_start` instruction advances into E (`id_valid` and not stalled);
  - otherwise decrements while nonzero;
  - `md_busy = (md_cnt != 0)`.
- Simultaneous events:
  - A start while busy is always stalled, so a reload never coincides with a nonzero count.
  - `raw_e` and `md_hz` together produce a single stall.

## Timing
- `stall_*` and `flush_e` are combinational from the D inputs and the registered E tags, within the same cycle.
- Tag latency: a D instruction appears on `WE_EM/WA_EM/WS_EM` 2 edges after advancing, and on `*_mw` 3 edges after.
- An RAW stall against E lasts exactly 1 cycle: the producer moves to M and is then forwarded.
- `md_busy` rises 1 edge after a start advances and stays high for `MD_LATENCY` cycles. A HI/LO read in D is released in the cycle `md_cnt` reaches 0.
- Reset (asynchronous, any time including mid-stall or mid-mul/div):
  - all tag registers go to 0 (`WE_EM = we_mw = 0`, `WA_* = 0`, `WS_* = 0`);
  - `md_cnt = 0`, so `md_busy = 0` and all stall outputs are 0 unless `raw_e` is from inputs only, which is impossible since `we_e = 0`.

## Configuration
- `HAZARD_MD_INTERLOCK_EN` defined: mul/div counter and `md_hz` are present, as described above.
- Not defined:
  - no counter is built;
  - `md_busy` is tied to 0 and `md_hz` is 0;
  - `id_md_start` and `id_reads_hilo` are ignored;
  - `MD_LATENCY` is unused.

## Structure
- Package `hazard_pkg` holds:
  - the writeback source encodings: `WS_ALU = 0`, `WS_MEM = 1`, `WS_PC8 = 2`, `WS_HI = 3`, `WS_LO = 4`, `WS_SHIFT = 5`;
  - the tag width constants `REG_AW = 5` and `WS_W = 3`.
- One sub-module, `md_busy_ctr`, holds the load/decrement counter. It is instantiated only under `HAZARD_MD_INTERLOCK_EN`.

## Test plan
- Reset mid-run: assert `rst_n = 0` while `WE_EM = 1`, `WA_EM = 8` and `md_cnt = 3` -> immediately `WE_EM = 0`, `WA_EM = 0`, `md_busy = 0`, all stalls 0.
- Load-use: a D write to `$t0` (8, `WS_MEM`), then a D read with `ra1 = 8`, `use1 = 1` -> stall for exactly 1 cycle. Next cycle `WA_EM = 8`, `WS_EM = 1`, no stall.
- `$zero` write: `id_wa = 0`, `id_we = 1`, followed by a read of reg 0 -> no stall.
- Unused operand: E writes reg 5, D has `ra2 = 5`, `use2 = 0` -> no stall. Same case with `use2 = 1` -> 1-cycle stall.
- Mul/div with `MD_LATENCY = 4`: issue `id_md_start`, then `id_reads_hilo` in the following cycle -> `md_busy` high for 4 cycles and the stall releases exactly when `md_cnt = 0`. A back-to-back `id_md_start` is likewise held.
- Macro off: same stimulus as the mul/div case -> `md_busy` stays 0 and no stall occurs.
